mem_dump_uart_tx: RTL
=====================

Name: mem_dump_uart_tx

Overview:
- Reader/transmitter end of the UART program path: the UART loader writes program and data memory; this block reads data-memory words back out and serialises them on a UART TX line.
- Lets the host check store results (e.g. halfword stores) over the serial link instead of through hierarchical probes.
- Sits beside data_mem inside cpu_uart_top.
- Owns one synchronous read port of data memory while busy.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (minimum 2).
- ADDR_WIDTH, 5, data-memory word-address width.
- COUNT_WIDTH, 6, width of word_count (ADDR_WIDTH+1, so a full memory dump is expressible).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; latched on accepted start.
- word_count  in  COUNT_WIDTH  number of words to send; latched on accepted start.
- mem_rd_en  out  1  data-memory read strobe.
- mem_addr  out  ADDR_WIDTH  data-memory word address.
- mem_rdata  in  32  read data, valid one cycle after the mem_rd_en edge (synchronous RAM).
- tx  out  1  UART serial out, 8N1, LSB first, idle high.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset (asynchronous, any state, mid-frame included) forces:
  - outputs: tx=1, busy=0, done=0, mem_rd_en=0, mem_addr=0.
  - state: IDLE; all counters 0.
- All outputs are registered.
- FSM states: IDLE, READ, WAIT, START_BIT, DATA_BITS, STOP_BIT, DONE.
- IDLE: start=1 at edge k latches base_addr and word_count and sets busy=1.
  - word_count=0: go to DONE; no memory read, tx stays 1.
  - Otherwise go to READ, with mem_rd_en=1 and mem_addr=current address after edge k.
- READ (1 cycle): deassert mem_rd_en; go to WAIT.
- WAIT (1 cycle): latch mem_rdata into the word shift register; byte index=0; go to START_BIT with tx=0.
  - tx therefore falls at edge k+2 after start is sampled.
- START_BIT: tx=0 for CLKS_PER_BIT cycles.
- DATA_BITS: 8 bits of the current byte, LSB first, each held CLKS_PER_BIT cycles.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles.
- Byte order within a word is little-endian: bits [7:0], [15:8], [23:16], [31:24].
- End of STOP_BIT:
  - byte index<3: increment byte index and go to START_BIT (no idle gap between bytes).
  - byte index=3 with words remaining: increment address and go to READ (2-cycle idle-high gap between words).
  - byte index=3 and last word: go to DONE.
- DONE (1 cycle): done=1 and busy=0 both registered from the same edge; return to IDLE.
- Address increments modulo 2^ADDR_WIDTH, so base_addr=31 with count 2 reads 31 then 0.
- Counters:
  - Bit-timer counts 0..CLKS_PER_BIT-1.
  - Bit counter counts 0..7.
  - Words-remaining counter decrements once per completed word.
- start while busy or in DONE is ignored; it is not queued.
- mem_rdata is sampled only in WAIT; changes at other times have no effect.
- Frame time is 10*CLKS_PER_BIT cycles per byte and 40*CLKS_PER_BIT+2 cycles per word.

Test Plan:
- Reset then idle:
  - rst held 5 cycles -> tx=1, busy=0, done=0, mem_rd_en=0 throughout.
  - Asserting rst asynchronously between clock edges -> outputs reach reset values immediately, without waiting for an edge.
- Single word (CLKS_PER_BIT=4, ram[1]=0x00120012, base_addr=1, word_count=1, start pulse):
  - mem_addr=1 read once.
  - Decoded bytes 0x12, 0x00, 0x12, 0x00, each with start=0 and stop=1.
  - tx low 2 cycles after start.
  - done pulses 162 cycles after start; busy falls on the same edge.
- Multi-word with wrap (ram[31]=0xA5A5A5A5, ram[0]=0x01020304, base_addr=31, word_count=2):
  - Byte stream A5 A5 A5 A5 04 03 02 01.
  - Exactly a 2-cycle tx-high gap between the two words.
  - done after 324 cycles.
- Zero count (word_count=0 with start):
  - busy high 1 cycle, then done pulse.
  - mem_rd_en never asserts; tx stays 1.
- Start while busy (second start pulse mid-frame during the single-word case):
  - Transmission is identical to the single-word case.
  - Exactly one done pulse; no second dump.
- Reset mid-frame:
  - rst asserted during DATA_BITS of byte 2 -> tx=1 and busy=0 immediately.
  - After release, a fresh start replays from base_addr with a clean frame.

Source files
------------

// File: rtl/mem_dump_uart_tx.sv
// Purpose: read data-memory words and stream them out as 8N1 UART bytes, little-endian within each word.
// Latency: tx start bit 2 cycles after start; done after 40*CLKS_PER_BIT+2 cycles per word (1 cycle for a zero count).
// Backpressure: none; start is accepted only in IDLE and is dropped, not queued, while busy or in DONE.
module mem_dump_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_WIDTH   = 5,
    parameter int COUNT_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [31:0]            mem_rdata,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_START_BIT,
        ST_DATA_BITS,
        ST_STOP_BIT,
        ST_DONE
    } state_t;

    state_t                 state, state_n;
    logic [TW-1:0]          timer, timer_n;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [1:0]             byte_idx, byte_idx_n;
    logic [COUNT_WIDTH-1:0] words_left, words_left_n;
    logic [31:0]            word_sr, word_sr_n;
    logic                   tx_n, busy_n, done_n, rd_en_n;
    logic [ADDR_WIDTH-1:0]  addr_n;

    // State, counters and every output are registered here; reset parks the line idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            words_left <= '0;
            word_sr    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bit_cnt    <= bit_cnt_n;
            byte_idx   <= byte_idx_n;
            words_left <= words_left_n;
            word_sr    <= word_sr_n;
            tx         <= tx_n;
            busy       <= busy_n;
            done       <= done_n;
            mem_rd_en  <= rd_en_n;
            mem_addr   <= addr_n;
        end
    end

    // Next-state and next-output logic; the word shift register drains LSB first so bytes leave little-endian.
    always_comb begin
        state_n      = state;
        timer_n      = timer;
        bit_cnt_n    = bit_cnt;
        byte_idx_n   = byte_idx;
        words_left_n = words_left;
        word_sr_n    = word_sr;
        tx_n         = tx;
        busy_n       = busy;
        done_n       = 1'b0;
        rd_en_n      = 1'b0;
        addr_n       = mem_addr;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_n       = 1'b1;
                    addr_n       = base_addr;
                    words_left_n = word_count;
                    timer_n      = '0;
                    if (word_count == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        rd_en_n = 1'b1;
                        state_n = ST_READ;
                    end
                end
            end
            ST_READ: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                // Synchronous RAM output is valid now, one cycle after the read strobe.
                word_sr_n  = mem_rdata;
                byte_idx_n = '0;
                bit_cnt_n  = '0;
                timer_n    = '0;
                tx_n       = 1'b0;
                state_n    = ST_START_BIT;
            end
            ST_START_BIT: begin
                if (timer == T_LAST) begin
                    timer_n   = '0;
                    bit_cnt_n = '0;
                    tx_n      = word_sr[0];
                    word_sr_n = {1'b0, word_sr[31:1]};
                    state_n   = ST_DATA_BITS;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_DATA_BITS: begin
                if (timer == T_LAST) begin
                    timer_n = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = ST_STOP_BIT;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        tx_n      = word_sr[0];
                        word_sr_n = {1'b0, word_sr[31:1]};
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_STOP_BIT: begin
                if (timer == T_LAST) begin
                    timer_n = '0;
                    if (byte_idx != 2'd3) begin
                        // Next byte of the same word follows back to back.
                        byte_idx_n = byte_idx + 2'd1;
                        tx_n       = 1'b0;
                        state_n    = ST_START_BIT;
                    end else begin
                        words_left_n = words_left - COUNT_WIDTH'(1);
                        if (words_left > COUNT_WIDTH'(1)) begin
                            // READ+WAIT leave tx high for two cycles between words.
                            addr_n  = mem_addr + ADDR_WIDTH'(1);
                            rd_en_n = 1'b1;
                            state_n = ST_READ;
                        end else begin
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = ST_DONE;
                        end
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_DONE: begin
                // Arriving from STOP_BIT, done is already high; a zero-count start arrives with done low
                // and raises it here so busy gets its one cycle first.
                if (done) begin
                    state_n = ST_IDLE;
                end else begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
